// File: rtl/input_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : input_ctrl_pkg
// Purpose  : Shared constants, instruction layout and helpers for the
//            multi-key input controller.
// Revision : 1.0
// ============================================================================
package input_ctrl_pkg;

    localparam logic [4:0] INTR_OPCODE  = 5'h15;
    localparam logic [4:0] FRAME_SRC_ID = 5'd31;

    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 27;
    localparam int SRC_MSB = 4;
    localparam int SRC_LSB = 0;

    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_PRESENT = 1'b1;

    // Lowest set bit wins; the frame source sits at bit 31 so it loses to every key.
    function automatic logic [4:0] pick_source(input logic [31:0] pend);
        logic [4:0] src;
        src = 5'd0;
        for (int i = 31; i >= 0; i--) begin
            if (pend[i]) begin
                src = 5'(i);
            end
        end
        return src;
    endfunction

    function automatic logic [31:0] encode_instr(input logic [4:0] src);
        logic [31:0] instr;
        instr                   = '0;
        instr[OPC_MSB:OPC_LSB]  = INTR_OPCODE;
        instr[SRC_MSB:SRC_LSB]  = src;
        return instr;
    endfunction

endpackage
`default_nettype wire

// File: rtl/key_debouncer.sv
`default_nettype none
// ============================================================================
// Module   : key_debouncer
// Purpose  : Two-flop synchroniser plus frame-sampled debounce for one key.
// Revision : 1.0
// ============================================================================
module key_debouncer #(
    parameter int DEBOUNCE_FRAMES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_key,
    input  logic i_sample,
    output logic o_rise
);

    logic [1:0] r_sync;
    logic       r_level;
    logic [3:0] r_cnt;

    logic       w_differs;
    logic [3:0] w_cnt_inc;
    logic       w_accept;

    // Run length only grows while every sample disagrees with the accepted level.
    assign w_differs = r_sync[1] ^ r_level;
    assign w_cnt_inc = r_cnt + 4'd1;
    assign w_accept  = i_sample & w_differs & (w_cnt_inc == 4'(DEBOUNCE_FRAMES));
    assign o_rise    = w_accept & ~r_level;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync  <= 2'b00;
            r_level <= 1'b0;
            r_cnt   <= 4'd0;
        end else begin
            r_sync <= {r_sync[0], i_key};
            if (i_sample) begin
                if (!w_differs) begin
                    r_cnt <= 4'd0;
                end else if (w_accept) begin
                    r_level <= ~r_level;
                    r_cnt   <= 4'd0;
                end else begin
                    r_cnt <= w_cnt_inc;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/multi_key_input_controller.sv
`default_nettype none
// ============================================================================
// Module   : multi_key_input_controller
// Purpose  : Frame-paced key debounce and prioritised interrupt presentation.
// Revision : 1.0
// ============================================================================
module multi_key_input_controller
    import input_ctrl_pkg::*;
#(
    parameter int NUM_KEYS        = 4,
    parameter int FRAME_DIVISOR   = 833333,
    parameter int DEBOUNCE_FRAMES = 2
) (
    input  logic                proc_clk,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] keys,
    input  logic [NUM_KEYS-1:0] key_mask,
    input  logic                irq_ack,
    output logic                irq_valid,
    output logic [31:0]         interrupt_instruction,
    output logic                frame_tick,
    output logic [7:0]          dropped_frames
);

    localparam int                 c_cnt_w    = (FRAME_DIVISOR > 1) ? $clog2(FRAME_DIVISOR) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(FRAME_DIVISOR - 1);

    logic [c_cnt_w-1:0]  r_frame_cnt;
    logic [31:0]         r_pend;
    logic [7:0]          r_dropped;
    logic [0:0]          r_state;
    logic [4:0]          r_src;

    logic                w_tick;
    logic [NUM_KEYS-1:0] w_rise;
    logic [31:0]         w_set;
    logic [31:0]         w_clr;
    logic [0:0]          w_state_nxt;
    logic                w_latch;

    // ---------------- frame timebase ----------------
    assign w_tick     = (r_frame_cnt == c_cnt_last);
    assign frame_tick = w_tick;

    always_ff @(posedge proc_clk or negedge reset) begin
        if (!reset) begin
            r_frame_cnt <= '0;
        end else if (w_tick) begin
            r_frame_cnt <= '0;
        end else begin
            r_frame_cnt <= r_frame_cnt + c_cnt_w'(1);
        end
    end

    // ---------------- per-key conditioning ----------------
    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
        key_debouncer #(
            .DEBOUNCE_FRAMES (DEBOUNCE_FRAMES)
        ) u_debouncer (
            .clk      (proc_clk),
            .rst_n    (reset),
            .i_key    (keys[k]),
            .i_sample (w_tick),
            .o_rise   (w_rise[k])
        );
    end

    // ---------------- pending sources ----------------
    always_comb begin
        w_set                 = '0;
        w_set[NUM_KEYS-1:0]   = w_rise & key_mask;
        w_set[FRAME_SRC_ID]   = w_tick;
    end

    assign w_clr   = ((r_state == ST_PRESENT) && irq_ack) ? (32'd1 << r_src) : 32'd0;
    assign w_latch = (r_state == ST_IDLE) && (|r_pend);

    // A set arriving in the same cycle as its clear takes priority.
    always_ff @(posedge proc_clk or negedge reset) begin
        if (!reset) begin
            r_pend <= '0;
        end else begin
            r_pend <= (r_pend & ~w_clr) | w_set;
        end
    end

    always_ff @(posedge proc_clk or negedge reset) begin
        if (!reset) begin
            r_dropped <= 8'd0;
        end else if (w_tick && r_pend[FRAME_SRC_ID] && !w_clr[FRAME_SRC_ID]
                     && (r_dropped != 8'hFF)) begin
            r_dropped <= r_dropped + 8'd1;
        end
    end

    assign dropped_frames = r_dropped;

    // ---------------- presentation FSM ----------------
    always_ff @(posedge proc_clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (|r_pend) begin
                    w_state_nxt = ST_PRESENT;
                end
            end
            ST_PRESENT: begin
                if (irq_ack) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge proc_clk or negedge reset) begin
        if (!reset) begin
            r_src <= 5'd0;
        end else if (w_latch) begin
            r_src <= pick_source(r_pend);
        end
    end

    // Outputs derive only from registers, so reset forces them low immediately.
    always_comb begin
        irq_valid             = 1'b0;
        interrupt_instruction = 32'd0;
        if (r_state == ST_PRESENT) begin
            irq_valid             = 1'b1;
            interrupt_instruction = encode_instr(r_src);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_multi_key_input_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_multi_key_input_controller
// Purpose  : Directed self-checking bench for multi_key_input_controller.
// Revision : 1.0
// ============================================================================
module tb_multi_key_input_controller;

    localparam logic [4:0] EXP_OPC = 5'h15;

    logic        proc_clk = 1'b0;
    logic        reset    = 1'b1;
    logic [3:0]  keys     = 4'h0;
    logic [3:0]  key_mask = 4'hF;
    logic        irq_ack  = 1'b0;
    logic        irq_valid;
    logic [31:0] interrupt_instruction;
    logic        frame_tick;
    logic [7:0]  dropped_frames;

    int n_pass  = 0;
    int n_total = 0;
    int tally[32];
    int order[$];
    int unstable;

    multi_key_input_controller #(
        .NUM_KEYS        (4),
        .FRAME_DIVISOR   (10),
        .DEBOUNCE_FRAMES (2)
    ) dut (
        .proc_clk              (proc_clk),
        .reset                 (reset),
        .keys                  (keys),
        .key_mask              (key_mask),
        .irq_ack               (irq_ack),
        .irq_valid             (irq_valid),
        .interrupt_instruction (interrupt_instruction),
        .frame_tick            (frame_tick),
        .dropped_frames        (dropped_frames)
    );

    always #5 proc_clk = ~proc_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [31:0] exp_instr(input int src);
        logic [4:0] s;
        s = 5'(src);
        return {EXP_OPC, 22'b0, s};
    endfunction

    task automatic clear_stats();
        for (int i = 0; i < 32; i++) tally[i] = 0;
        order.delete();
        unstable = 0;
    endtask

    // Acknowledges every request seen, after holding it for 'hold' cycles.
    task automatic service(input int ncyc, input int hold);
        logic [31:0] snap;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge proc_clk);
            irq_ack = 1'b0;
            if (irq_valid) begin
                snap = interrupt_instruction;
                for (int h = 0; h < hold; h++) begin
                    @(negedge proc_clk);
                    if (!irq_valid || interrupt_instruction !== snap) unstable++;
                end
                tally[snap[4:0]]++;
                order.push_back(int'(snap[4:0]));
                irq_ack = 1'b1;
            end
        end
        @(negedge proc_clk);
        irq_ack = 1'b0;
    endtask

    task automatic wait_valid(input int budget, output bit found);
        found = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (irq_valid) begin
                found = 1'b1;
                break;
            end
            @(negedge proc_clk);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge proc_clk);
        n_total++;
        if (irq_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", irq_valid);
        else n_pass++;
        n_total++;
        if (interrupt_instruction !== 32'd0) $display("FAIL reset_instr: got %h want 0", interrupt_instruction);
        else n_pass++;
        n_total++;
        if (frame_tick !== 1'b0) $display("FAIL reset_tick: got %b want 0", frame_tick);
        else n_pass++;
        n_total++;
        if (dropped_frames !== 8'd0) $display("FAIL reset_dropped: got %0d want 0", dropped_frames);
        else n_pass++;
    endtask

    task automatic test_frame();
        bit tk[64];
        bit vl[64];
        int ticks;
        reset = 1'b1;
        for (int n = 1; n <= 12; n++) begin
            @(negedge proc_clk);
            tk[n] = frame_tick;
            vl[n] = irq_valid;
        end
        n_total++;
        if ({tk[8], tk[9], tk[10]} !== 3'b010) $display("FAIL first_tick: got %b want 010", {tk[8], tk[9], tk[10]});
        else n_pass++;
        n_total++;
        if ({vl[10], vl[11]} !== 2'b01) $display("FAIL irq_latency: got %b want 01", {vl[10], vl[11]});
        else n_pass++;
        n_total++;
        if (interrupt_instruction !== exp_instr(31)) $display("FAIL first_src: got %h want %h", interrupt_instruction, exp_instr(31));
        else n_pass++;
        irq_ack = 1'b1;
        @(negedge proc_clk);
        irq_ack = 1'b0;
        n_total++;
        if ({irq_valid, interrupt_instruction} !== 33'd0) $display("FAIL ack_clears: got valid=%b instr=%h want 0/0", irq_valid, interrupt_instruction);
        else n_pass++;
        ticks = 0;
        for (int n = 14; n <= 40; n++) begin
            @(negedge proc_clk);
            tk[n]   = frame_tick;
            ticks  += int'(frame_tick);
            irq_ack = irq_valid;
        end
        irq_ack = 1'b0;
        n_total++;
        if (!(tk[19] && tk[29] && tk[39] && ticks == 3)) $display("FAIL tick_period: got ticks=%0d at19=%b at29=%b at39=%b want 3/1/1/1", ticks, tk[19], tk[29], tk[39]);
        else n_pass++;
        n_total++;
        if (dropped_frames !== 8'd0) $display("FAIL prompt_dropped: got %0d want 0", dropped_frames);
        else n_pass++;
    endtask

    task automatic test_debounce();
        clear_stats();
        fork
            begin
                keys[2] = 1'b1;
                repeat (30) @(negedge proc_clk);
                keys[2] = 1'b0;
            end
            service(80, 0);
        join
        fork
            begin
                keys[1] = 1'b1;
                repeat (10) @(negedge proc_clk);
                keys[1] = 1'b0;
            end
            service(60, 0);
        join
        n_total++;
        if (tally[2] != 1) $display("FAIL held_key2: got %0d requests want 1", tally[2]);
        else n_pass++;
        n_total++;
        if (tally[1] != 0) $display("FAIL glitch_key1: got %0d requests want 0", tally[1]);
        else n_pass++;
    endtask

    task automatic test_same_frame();
        int idx;
        logic [14:0] seq;
        clear_stats();
        fork
            begin
                keys = 4'b1001;
                repeat (30) @(negedge proc_clk);
                keys = 4'b0000;
            end
            service(90, 1);
        join
        idx = -1;
        for (int i = 0; i < order.size(); i++) begin
            if (order[i] == 0 && idx < 0) idx = i;
        end
        seq = 15'h7FFF;
        if (idx >= 0 && idx + 2 < order.size()) seq = {5'(order[idx]), 5'(order[idx+1]), 5'(order[idx+2])};
        n_total++;
        if (seq !== {5'd0, 5'd3, 5'd31}) $display("FAIL same_frame_order: got %h want %h", seq, {5'd0, 5'd3, 5'd31});
        else n_pass++;
        n_total++;
        if (tally[0] != 1 || tally[3] != 1) $display("FAIL same_frame_count: got k0=%0d k3=%0d want 1/1", tally[0], tally[3]);
        else n_pass++;
        n_total++;
        if (unstable != 0) $display("FAIL held_until_ack: got %0d unstable cycles want 0", unstable);
        else n_pass++;
    endtask

    task automatic test_mask();
        clear_stats();
        key_mask = 4'b1011;
        fork
            begin
                keys[2] = 1'b1;
                repeat (30) @(negedge proc_clk);
                keys[2] = 1'b0;
            end
            service(80, 0);
        join
        n_total++;
        if (tally[2] != 0) $display("FAIL masked_key2: got %0d requests want 0", tally[2]);
        else n_pass++;
        key_mask = 4'hF;
        irq_ack  = 1'b0;
        keys[2]  = 1'b1;
        repeat (30) @(negedge proc_clk);
        keys[2]  = 1'b0;
        key_mask = 4'b1011;
        service(80, 0);
        key_mask = 4'hF;
        n_total++;
        if (tally[2] != 1) $display("FAIL pending_before_mask: got %0d requests want 1", tally[2]);
        else n_pass++;
    endtask

    task automatic test_overrun();
        bit found;
        int bad;
        irq_ack = 1'b0;
        wait_valid(30, found);
        n_total++;
        if (!found) $display("FAIL overrun_start: got no request want irq_valid within 30 cycles");
        else n_pass++;
        bad = 0;
        repeat (3000) begin
            @(negedge proc_clk);
            if (irq_valid !== 1'b1) bad++;
        end
        n_total++;
        if (dropped_frames !== 8'd255) $display("FAIL dropped_saturate: got %0d want 255", dropped_frames);
        else n_pass++;
        n_total++;
        if (bad != 0) $display("FAIL valid_held: got %0d low cycles want 0", bad);
        else n_pass++;
        n_total++;
        if (interrupt_instruction !== exp_instr(31)) $display("FAIL overrun_src: got %h want %h", interrupt_instruction, exp_instr(31));
        else n_pass++;
        service(40, 0);
        n_total++;
        if (dropped_frames !== 8'd255) $display("FAIL dropped_sticky: got %0d want 255", dropped_frames);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        bit found;
        bit vl[64];
        bit early;
        wait_valid(30, found);
        n_total++;
        if (!found) $display("FAIL reset_mid_start: got no request want irq_valid within 30 cycles");
        else n_pass++;
        @(negedge proc_clk);
        #2 reset = 1'b0;
        #1;
        n_total++;
        if ({irq_valid, interrupt_instruction} !== 33'd0) $display("FAIL async_abort: got valid=%b instr=%h want 0/0", irq_valid, interrupt_instruction);
        else n_pass++;
        n_total++;
        if (dropped_frames !== 8'd0) $display("FAIL async_dropped: got %0d want 0", dropped_frames);
        else n_pass++;
        repeat (2) @(negedge proc_clk);
        reset = 1'b1;
        early = 1'b0;
        for (int n = 1; n <= 11; n++) begin
            @(negedge proc_clk);
            vl[n] = irq_valid;
            if (n <= 10 && irq_valid) early = 1'b1;
        end
        n_total++;
        if (early !== 1'b0) $display("FAIL no_resurrect: got request before frame_tick want none");
        else n_pass++;
        n_total++;
        if (vl[11] !== 1'b1 || interrupt_instruction !== exp_instr(31)) $display("FAIL post_reset_req: got valid=%b instr=%h want 1/%h", vl[11], interrupt_instruction, exp_instr(31));
        else n_pass++;
        service(20, 0);
    endtask

    initial begin
        test_reset();
        test_frame();
        test_debounce();
        test_same_frame();
        test_mask();
        test_overrun();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/multi_key_input_controller.md
MULTI_KEY_INPUT_CONTROLLER -- requirements
Module: multi_key_input_controller

Interface
REQ-001 SHALL have parameter NUM_KEYS, default 4, number of key input channels (1..31).
REQ-002 SHALL have parameter FRAME_DIVISOR, default 833333, proc_clk cycles per frame (50 MHz / 60 fps).
REQ-003 SHALL have parameter DEBOUNCE_FRAMES, default 2, consecutive equal frame samples needed to accept a key level (1..15).
REQ-004 SHALL have port proc_clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port keys  input  NUM_KEYS  raw asynchronous key levels, 1 = pressed.
REQ-007 SHALL have port key_mask  input  NUM_KEYS  1 = channel enabled.
REQ-008 SHALL have port irq_ack  input  1  processor acknowledge of the presented interrupt.
REQ-009 SHALL have port irq_valid  output  1  interrupt_instruction holds a valid request.
REQ-010 SHALL have port interrupt_instruction  output  32  encoded interrupt instruction, 0 when not valid.
REQ-011 SHALL have port frame_tick  output  1  one-cycle pulse at each frame boundary.
REQ-012 SHALL have port dropped_frames  output  8  saturating count of frame events lost to overrun.

Function
REQ-013 SHALL pass each key through a 2-flop synchroniser before any other use.
REQ-014 SHALL count 0..FRAME_DIVISOR-1, assert frame_tick during the cycle the count equals FRAME_DIVISOR-1, and wrap to 0 on the next edge.
REQ-015 SHALL sample the synchronised keys only on frame_tick cycles; a channel's debounced level changes when DEBOUNCE_FRAMES consecutive samples agree and differ from it.
REQ-016 SHALL set pending[k] on the edge ending a frame_tick cycle in which debounced level k rises 0->1 and key_mask[k]=1; falling edges create no event.
REQ-017 SHALL set frame_pending on every frame_tick; if already set and not cleared in that cycle, it stays set and dropped_frames increments, saturating at 255.
REQ-018 SHALL keep pending bits set regardless of later mask changes until serviced.
REQ-019 SHALL use FSM IDLE/PRESENT; IDLE -> PRESENT when any pending bit is set, latching the winner into the output register (one-cycle latency from pending to irq_valid).
REQ-020 SHALL prioritise lowest key index highest and the frame source lowest.
REQ-021 SHALL, in PRESENT, hold irq_valid=1 and interrupt_instruction stable until irq_ack=1, then clear the served pending bit, drive irq_valid=0 and return to IDLE (at least one IDLE cycle between requests).
REQ-022 SHALL ignore irq_ack in IDLE.
REQ-023 SHALL let set win when a source's pending bit is set and cleared in the same cycle.
REQ-024 SHALL encode interrupt_instruction as {INTR_OPCODE[4:0], 22'b0, src_id[4:0]}, src_id = key index, or 31 for frame.

Reset
REQ-025 SHALL, while reset=0, clear counter, synchronisers, debounce state, pending bits and dropped_frames, enter IDLE, and drive irq_valid=0, interrupt_instruction=0 and frame_tick=0.
REQ-026 SHALL abort any in-flight request on reset mid-PRESENT, with no event resurrected after release.

Structure
REQ-027 SHALL place INTR_OPCODE, FRAME_SRC_ID=31 and the instruction field positions in shared package input_ctrl_pkg.
REQ-028 SHALL implement per-channel sync+debounce in one sub-module key_debouncer, instantiated NUM_KEYS times.

Verification (NUM_KEYS=4, FRAME_DIVISOR=10, DEBOUNCE_FRAMES=2)
REQ-029 SHALL check that, with no keys held, frame_tick pulses every 10 cycles, the first request is src 31 and dropped_frames stays 0 when irq_ack is given within 5 cycles.
REQ-030 SHALL check that holding keys[2]=1 for 3 frames yields exactly one request with src_id=2, and a 1-frame glitch on keys[1] yields none.
REQ-031 SHALL check that keys 0 and 3 accepted in the same frame are presented as src 0, then src 3, then 31, each held until irq_ack.
REQ-032 SHALL check that never acking for 300 frames gives dropped_frames=255 with irq_valid held at 1.
REQ-033 SHALL check that key_mask[2]=0 suppresses key 2 events, while a key 2 event already pending before masking is still delivered.
REQ-034 SHALL check that asserting reset=0 mid-PRESENT drives irq_valid=0 immediately (asynchronously) and that, after release, the first request arrives only after the next frame_tick.
